ib_vnu3_c2v_feeder: RTL and testbench



---
 rtl/ib_vnu3_c2v_feeder.sv | 167 ++++++++++++++++
 tb/tb_ib_vnu3_c2v_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_vnu3_c2v_feeder.sv
// Upstream feeder for the degree-3 IB variable-node unit: registers c2v messages and the
// channel LLR onto the VNU routes and emits a sideband tag aligned to the c2v pipelines.
module ib_vnu3_c2v_feeder #(
   parameter int unsigned QUAN_SIZE      = 3,
   parameter int unsigned PIPELINE_DEPTH = 3,
   parameter int unsigned LAYER_NUM      = 4,
   parameter int unsigned MAX_ITER       = 8,
   localparam int unsigned LAYER_W       = $clog2(LAYER_NUM),
   localparam int unsigned ITER_W        = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1
) (
   input  logic                 read_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop_req,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [QUAN_SIZE-1:0] c2v0_in,
   input  logic [QUAN_SIZE-1:0] c2v1_in,
   input  logic [QUAN_SIZE-1:0] c2v2_in,
   input  logic [QUAN_SIZE-1:0] ch_llr_in,
   output logic [QUAN_SIZE-1:0] E0,
   output logic [QUAN_SIZE-1:0] E1,
   output logic [QUAN_SIZE-1:0] E2,
   output logic [QUAN_SIZE-1:0] ch_llr,
   output logic                 issue_valid,
   output logic                 v2c_src,
   output logic                 tag_valid,
   output logic [LAYER_W-1:0]   tag_layer,
   output logic [ITER_W-1:0]    tag_iter,
   output logic                 tag_v2c_src,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned TAG_DEPTH = PIPELINE_DEPTH - 1;
   localparam int unsigned DRAIN_W   = $clog2(PIPELINE_DEPTH) + 1;
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
   localparam logic [ITER_W-1:0]  LAST_ITER  = ITER_W'(MAX_ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic               valid;
      logic [LAYER_W-1:0] layer;
      logic [ITER_W-1:0]  iter;
      logic               src;
   } tag_t;

   state_t             state_q, state_d;
   logic [LAYER_W-1:0] layer_q, layer_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic               stop_pend_q, stop_pend_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               accept;
   logic [LAYER_W-1:0] issue_layer;
   logic [ITER_W-1:0]  issue_iter;
   tag_t               tag_pipe [TAG_DEPTH];

   always_ff @(posedge read_clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         layer_q     <= '0;
         iter_q      <= '0;
         stop_pend_q <= 1'b0;
         drain_q     <= '0;
      end else begin
         state_q     <= state_d;
         layer_q     <= layer_d;
         iter_q      <= iter_d;
         stop_pend_q <= stop_pend_d;
         drain_q     <= drain_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      layer_d     = layer_q;
      iter_d      = iter_q;
      stop_pend_d = stop_pend_q;
      drain_d     = drain_q;
      in_ready    = 1'b0;
      accept      = 1'b0;
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_RUN;
               layer_d     = '0;
               iter_d      = '0;
               stop_pend_d = 1'b0;
            end
         end
         S_RUN: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (stop_req) stop_pend_d = 1'b1;
            if (accept) begin
               if (layer_q == LAST_LAYER) begin
                  layer_d = '0;
                  // a stop only ends the codeword at an iteration boundary
                  if ((iter_q == LAST_ITER) || stop_pend_q || stop_req) begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_W'(TAG_DEPTH);
                  end else begin
                     iter_d = iter_q + ITER_W'(1);
                  end
               end else begin
                  layer_d = layer_q + LAYER_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - DRAIN_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge read_clk) begin
      if (rst) begin
         E0          <= '0;
         E1          <= '0;
         E2          <= '0;
         ch_llr      <= '0;
         issue_valid <= 1'b0;
         v2c_src     <= 1'b0;
         issue_layer <= '0;
         issue_iter  <= '0;
      end else begin
         issue_valid <= accept;
         if (accept) begin
            E0          <= c2v0_in;
            E1          <= c2v1_in;
            E2          <= c2v2_in;
            ch_llr      <= ch_llr_in;
            v2c_src     <= (iter_q == '0);
            issue_layer <= layer_q;
            issue_iter  <= iter_q;
         end
      end
   end

   // Stage 0 follows the issue register, so the last stage lines up with E1_reg/E2_reg.
   always_ff @(posedge read_clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= issue_valid ? tag_t'{valid: 1'b1, layer: issue_layer,
                                             iter: issue_iter, src: v2c_src} : '0;
         for (int unsigned i = 1; i < TAG_DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign tag_valid   = tag_pipe[TAG_DEPTH-1].valid;
   assign tag_layer   = tag_pipe[TAG_DEPTH-1].layer;
   assign tag_iter    = tag_pipe[TAG_DEPTH-1].iter;
   assign tag_v2c_src = tag_pipe[TAG_DEPTH-1].src;

endmodule

// File: tb/tb_ib_vnu3_c2v_feeder.sv
// Self-checking bench for ib_vnu3_c2v_feeder: randomized beats against a beat-count model
// (layer = beat % LAYER_NUM, iteration = beat / LAYER_NUM, stop rounds up to the iteration end).
module tb_ib_vnu3_c2v_feeder;
   localparam int unsigned QS = 3;
   localparam int unsigned PD = 3;
   localparam int unsigned LN = 4;
   localparam int unsigned MI = 8;
   localparam int unsigned TD = PD - 1;
   localparam int unsigned LW = $clog2(LN);
   localparam int unsigned IW = (MI > 1) ? $clog2(MI) : 1;
   localparam int unsigned AW = 6 + 4*QS + LW + IW + 1;

   logic          read_clk = 1'b0;
   logic          rst, start, stop_req, in_valid, in_ready;
   logic [QS-1:0] c2v0_in, c2v1_in, c2v2_in, ch_llr_in;
   logic [QS-1:0] E0, E1, E2, ch_llr;
   logic          issue_valid, v2c_src, tag_valid, tag_v2c_src, busy, done;
   logic [LW-1:0] tag_layer;
   logic [IW-1:0] tag_iter;

   ib_vnu3_c2v_feeder #(.QUAN_SIZE(QS), .PIPELINE_DEPTH(PD), .LAYER_NUM(LN), .MAX_ITER(MI)) dut (
      .read_clk(read_clk), .rst(rst), .start(start), .stop_req(stop_req),
      .in_valid(in_valid), .in_ready(in_ready),
      .c2v0_in(c2v0_in), .c2v1_in(c2v1_in), .c2v2_in(c2v2_in), .ch_llr_in(ch_llr_in),
      .E0(E0), .E1(E1), .E2(E2), .ch_llr(ch_llr),
      .issue_valid(issue_valid), .v2c_src(v2c_src),
      .tag_valid(tag_valid), .tag_layer(tag_layer), .tag_iter(tag_iter), .tag_v2c_src(tag_v2c_src),
      .busy(busy), .done(done)
   );

   always #5 read_clk = ~read_clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // reference model state
   int            m_cyc = 64;
   bit            m_run, m_pend, m_acc, m_src;
   int            m_count, m_limit, m_done_edge;
   logic [QS-1:0] m_d [4];
   bit            h_v [64];
   int            h_l [64];
   int            h_i [64];
   bit            h_s [64];

   function automatic int hidx();
      return (m_cyc - int'(TD)) % 64;
   endfunction

   function automatic logic [AW-1:0] exp_all();
      int i = hidx();
      logic [LW+IW:0] t;
      t = h_v[i] ? {LW'(h_l[i]), IW'(h_i[i]), h_s[i]} : '0;
      return {m_run, m_acc, m_src, m_pend && (m_cyc == m_done_edge), m_run || m_pend, h_v[i],
              m_d[0], m_d[1], m_d[2], m_d[3], t};
   endfunction

   function automatic logic [AW-1:0] obs_all();
      logic [LW+IW:0] t;
      t = tag_valid ? {tag_layer, tag_iter, tag_v2c_src} : '0;
      return {in_ready, issue_valid, v2c_src, done, busy, tag_valid, E0, E1, E2, ch_llr, t};
   endfunction

   task automatic rand_data();
      c2v0_in   = QS'($urandom);
      c2v1_in   = QS'($urandom);
      c2v2_in   = QS'($urandom);
      ch_llr_in = QS'($urandom);
   endtask

   // One clock edge: inputs are stable across it, model updates to post-edge expectations.
   task automatic advance();
      bit acc;
      int k;
      acc = m_run && in_valid && !rst;
      @(posedge read_clk);
      #1;
      m_cyc++;
      k = m_count;
      m_acc = acc;
      h_v[m_cyc % 64] = acc;
      h_l[m_cyc % 64] = 0;
      h_i[m_cyc % 64] = 0;
      h_s[m_cyc % 64] = 1'b0;
      if (rst) begin
         m_run = 1'b0; m_pend = 1'b0; m_src = 1'b0;
         foreach (m_d[j]) m_d[j] = '0;
         foreach (h_v[j]) h_v[j] = 1'b0;
         return;
      end
      if (acc) begin
         m_d[0] = c2v0_in; m_d[1] = c2v1_in; m_d[2] = c2v2_in; m_d[3] = ch_llr_in;
         m_src = (k / int'(LN) == 0);
         h_l[m_cyc % 64] = k % int'(LN);
         h_i[m_cyc % 64] = k / int'(LN);
         h_s[m_cyc % 64] = m_src;
         m_count++;
      end
      if (m_run && stop_req && ((k / int'(LN)) + 1) * int'(LN) < m_limit)
         m_limit = ((k / int'(LN)) + 1) * int'(LN);
      if (m_run) begin
         if (m_count == m_limit) begin
            m_run = 1'b0; m_pend = 1'b1; m_done_edge = m_cyc + int'(PD);
         end
      end else if (!m_pend && start) begin
         m_run = 1'b1; m_count = 0; m_limit = int'(LN * MI);
      end else if (m_pend && m_cyc > m_done_edge) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop_req = 1'b0; in_valid = 1'b0; rand_data();
      advance();
      advance();
      n_checks++;
      if ({in_ready, issue_valid, v2c_src, tag_valid, tag_v2c_src, busy, done,
           E0, E1, E2, ch_llr, tag_layer, tag_iter} !== '0)
         $display("FAIL reset_outputs got=%b required all zero",
                  {in_ready, issue_valid, v2c_src, tag_valid, tag_v2c_src, busy, done,
                   E0, E1, E2, ch_llr, tag_layer, tag_iter});
      else n_pass++;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; rand_data();
         advance();
         n_checks++;
         if ({in_ready, issue_valid} !== 2'b00)
            $display("FAIL idle_no_accept cyc=%0d got=%b required=00", m_cyc, {in_ready, issue_valid});
         else n_pass++;
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL idle cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
      end
   endtask

   task automatic test_full_run();
      int n_iss = 0, n_src = 0, n_done = 0, last_iss = 0, done_at = 0;
      start = 1'b1; in_valid = 1'b0; rand_data();
      advance();
      start = 1'b0;
      for (int c = 0; c < 45; c++) begin
         in_valid = 1'b1; rand_data();
         c2v0_in = QS'(m_count % 8);
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL full_run cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
         if (issue_valid) begin n_iss++; last_iss = m_cyc; if (v2c_src) n_src++; end
         if (done) begin n_done++; done_at = m_cyc; end
      end
      n_checks++;
      if (n_iss != 32) $display("FAIL full_run_beats got=%0d required=32", n_iss); else n_pass++;
      n_checks++;
      if (n_src != 4) $display("FAIL full_run_v2c_src_beats got=%0d required=4", n_src); else n_pass++;
      n_checks++;
      if (n_done != 1 || done_at - last_iss != 3)
         $display("FAIL full_run_done pulses=%0d delay=%0d required 1 pulse, delay 3", n_done, done_at - last_iss);
      else n_pass++;
      n_checks++;
      if ({in_ready, busy} !== 2'b00) $display("FAIL full_run_idle got=%b required=00", {in_ready, busy});
      else n_pass++;
   endtask

   task automatic test_bubbles();
      int n_iss = 0;
      start = 1'b1; in_valid = 1'b0; rand_data();
      advance();
      start = 1'b0;
      for (int c = 0; c < 70; c++) begin
         in_valid = (c >= 20) || (c % 2 == 0); rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL bubbles cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
         if (c < 20 && issue_valid) n_iss++;
      end
      n_checks++;
      if (n_iss != 10) $display("FAIL bubbles_accepts got=%0d required=10", n_iss); else n_pass++;
   endtask

   task automatic test_early_stop();
      int n_iss = 0, n_done = 0;
      start = 1'b1; in_valid = 1'b0; rand_data();
      advance();
      start = 1'b0;
      for (int c = 0; c < 25; c++) begin
         in_valid = 1'b1; stop_req = (m_count == 9); rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL early_stop cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
         if (issue_valid) n_iss++;
         if (done) n_done++;
      end
      stop_req = 1'b0;
      n_checks++;
      if (n_iss != 12 || n_done != 1)
         $display("FAIL early_stop_beats got=%0d beats %0d done required 12 beats 1 done", n_iss, n_done);
      else n_pass++;
   endtask

   task automatic test_stop_at_boundary();
      int n_iss = 0, n_done = 0;
      start = 1'b1; in_valid = 1'b0; rand_data();
      advance();
      start = 1'b0;
      for (int c = 0; c < 15; c++) begin
         in_valid = 1'b1; stop_req = (m_count == 3); rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL stop_boundary cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
         if (issue_valid) n_iss++;
         if (done) n_done++;
      end
      stop_req = 1'b0;
      n_checks++;
      if (n_iss != 4 || n_done != 1)
         $display("FAIL stop_boundary_beats got=%0d beats %0d done required 4 beats 1 done", n_iss, n_done);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      int n_done = 0, first_src = -1;
      start = 1'b1; in_valid = 1'b0; rand_data();
      advance();
      start = 1'b0;
      for (int c = 0; c < 14; c++) begin
         in_valid = 1'b1; rand_data();
         advance();
      end
      rst = 1'b1; rand_data();
      advance();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, issue_valid, v2c_src, tag_valid, tag_v2c_src, busy, done,
           E0, E1, E2, ch_llr, tag_layer, tag_iter} !== '0)
         $display("FAIL mid_reset_outputs got=%b required all zero",
                  {in_ready, issue_valid, v2c_src, tag_valid, tag_v2c_src, busy, done,
                   E0, E1, E2, ch_llr, tag_layer, tag_iter});
      else n_pass++;
      for (int c = 0; c < 50; c++) begin
         start = (c == 8); in_valid = 1'b1; rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL mid_reset cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
         if (c < 8 && done) n_done++;
         if (issue_valid && first_src < 0) first_src = int'(v2c_src);
      end
      start = 1'b0;
      n_checks++;
      if (n_done != 0) $display("FAIL mid_reset_no_done got=%0d pulses required=0", n_done); else n_pass++;
      n_checks++;
      if (first_src != 1) $display("FAIL mid_reset_restart_src got=%0d required=1", first_src); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         start    = (c % 60 == 0) || ($urandom_range(0, 15) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         stop_req = ($urandom_range(0, 19) == 0);
         rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL random cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
      end
      start = 1'b0; stop_req = 1'b0;
      for (int c = 0; c < 45; c++) begin
         in_valid = 1'b1; rand_data();
         advance();
         n_checks++;
         if (obs_all() !== exp_all())
            $display("FAIL random_flush cyc=%0d got=%b exp=%b", m_cyc, obs_all(), exp_all());
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL random_final_idle got busy=%b required=0", busy); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop_req = 1'b0; in_valid = 1'b0;
      c2v0_in = '0; c2v1_in = '0; c2v2_in = '0; ch_llr_in = '0;
      test_reset();
      test_full_run();
      test_bubbles();
      test_early_stop();
      test_stop_at_boundary();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
